// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low gfedcba, bit 0 = a) and monitor state types.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int STAB_W = 8;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } seq_state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low segment pattern to a BCD digit.
// Zero latency; no flow control.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [3:0] o_digit,
    output logic       o_is_digit,
    output logic       o_is_blank
);
    always_comb begin
        o_digit    = 4'd0;
        o_is_digit = 1'b1;
        o_is_blank = 1'b0;
        case (i_pat)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: begin
                o_is_digit = 1'b0;
                o_is_blank = 1'b1;
            end
            default:   o_is_digit = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg7_monitor.sv
// Glitch-filters a segment bus, decodes accepted patterns and checks the mod-10 up-count.
// Results appear STABLE_CYCLES edges after the input register captures a change; never stalls.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           seg,
    output logic [3:0]           bcd,
    output logic                 digit_valid,
    output logic                 blank,
    output logic                 pattern_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam logic [6:0]        SEG_OFF  = ACTIVE_LOW ? SEG_BLANK : 7'h00;
    localparam logic [STAB_W-1:0] STAB_MAX = STABLE_CYCLES[STAB_W-1:0];

    logic [6:0]           r_seg_q;
    logic [6:0]           r_last_pat;
    logic                 r_has_last;
    logic [STAB_W-1:0]    r_stab_cnt;
    seq_state_t           r_state;
    logic [3:0]           r_expected;
    logic [3:0]           r_bcd;
    logic                 r_digit_valid;
    logic                 r_blank;
    logic                 r_pattern_err;
    logic                 r_seq_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [6:0] w_norm;
    logic [3:0] w_digit;
    logic       w_is_digit;
    logic       w_is_blank;
    logic       w_changed;
    logic       w_accept;
    logic       w_seq_miss;
    logic       w_err_event;

    assign w_norm = ACTIVE_LOW ? r_seg_q : ~r_seg_q;

    seg7_to_bcd u_dec (
        .i_pat      (w_norm),
        .o_digit    (w_digit),
        .o_is_digit (w_is_digit),
        .o_is_blank (w_is_blank)
    );

    // Accept on the single edge the run reaches STABLE_CYCLES; the last pattern is never re-reported.
    assign w_changed   = (seg != r_seg_q);
    assign w_accept    = !w_changed && (r_stab_cnt == STAB_MAX - 8'd1)
                         && !(r_has_last && (r_seg_q == r_last_pat));
    assign w_seq_miss  = (r_state == ST_LOCKED) && (w_digit != r_expected);
    assign w_err_event = w_accept && ((w_is_digit && w_seq_miss) || (!w_is_digit && !w_is_blank));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_q       <= SEG_OFF;
            r_last_pat    <= SEG_OFF;
            r_has_last    <= 1'b0;
            r_stab_cnt    <= '0;
            r_state       <= ST_UNLOCKED;
            r_expected    <= 4'd0;
            r_bcd         <= 4'd0;
            r_digit_valid <= 1'b0;
            r_blank       <= 1'b0;
            r_pattern_err <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_seg_q       <= seg;
            r_digit_valid <= 1'b0;
            r_pattern_err <= 1'b0;
            r_seq_err     <= 1'b0;

            if (w_changed)
                r_stab_cnt <= '0;
            else if (r_stab_cnt != STAB_MAX)
                r_stab_cnt <= r_stab_cnt + 8'd1;

            if (w_accept) begin
                r_last_pat <= r_seg_q;
                r_has_last <= 1'b1;
                if (w_is_digit) begin
                    r_bcd         <= w_digit;
                    r_blank       <= 1'b0;
                    r_digit_valid <= 1'b1;
                    r_seq_err     <= w_seq_miss;
                    r_state       <= ST_LOCKED;
                    r_expected    <= (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
                end else if (w_is_blank) begin
                    r_blank <= 1'b1;
                    r_state <= ST_UNLOCKED;
                end else begin
                    r_pattern_err <= 1'b1;
                    r_state       <= ST_UNLOCKED;
                end
            end

            if (w_err_event && (r_err_count != '1))
                r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bcd         = r_bcd;
    assign digit_valid = r_digit_valid;
    assign blank       = r_blank;
    assign pattern_err = r_pattern_err;
    assign seq_err     = r_seq_err;
    assign locked      = (r_state == ST_LOCKED);
    assign err_count   = r_err_count;
endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: run-length reference model compared every cycle plus directed literals.
module tb_seg7_monitor;
    localparam int S   = 4;
    localparam int W   = 8;
    localparam int SAT = (1 << W) - 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg   = 7'h7F;
    logic [3:0] bcd;
    logic       digit_valid, blank, pattern_err, seq_err, locked;
    logic [W-1:0] err_count;

    seg7_monitor #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1), .ERR_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .seg(seg), .bcd(bcd), .digit_valid(digit_valid),
        .blank(blank), .pattern_err(pattern_err), .seq_err(seq_err),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Returns 0..9 for a digit, 10 for blank, -1 for anything else.
    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (p == pat_tab[i]) return i;
        if (p == 7'h7F) return 10;
        return -1;
    endfunction

    // Reference model: a pattern is reported when the run of identical samples
    // (the register's all-off reset value counting as the first) reaches S+1.
    logic [6:0] m_prev, m_last;
    int  m_run, m_expect;
    bit  m_has_last;
    int  e_bcd, e_dv, e_blank, e_perr, e_serr, e_locked, e_err;

    task automatic model_reset();
        m_prev = 7'h7F; m_run = 1; m_has_last = 0; m_last = 7'h7F; m_expect = 0;
        e_bcd = 0; e_dv = 0; e_blank = 0; e_perr = 0; e_serr = 0; e_locked = 0; e_err = 0;
    endtask

    task automatic bump_err();
        if (e_err < SAT) e_err++;
    endtask

    task automatic model_step();
        int d;
        e_dv = 0; e_perr = 0; e_serr = 0;
        if (seg == m_prev) m_run++;
        else m_run = 1;
        m_prev = seg;
        if (m_run == S + 1 && !(m_has_last && m_last == m_prev)) begin
            m_has_last = 1;
            m_last = m_prev;
            d = decode(m_prev);
            if (d >= 0 && d <= 9) begin
                e_dv = 1; e_bcd = d; e_blank = 0;
                if (e_locked == 1 && d != m_expect) begin
                    e_serr = 1;
                    bump_err();
                end
                e_locked = 1;
                m_expect = (d + 1) % 10;
            end else if (d == 10) begin
                e_blank = 1; e_locked = 0;
            end else begin
                e_perr = 1; e_locked = 0;
                bump_err();
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        #2;
        forever begin
            @(negedge clk);
            chk("bcd", int'(bcd), e_bcd);
            chk("digit_valid", int'(digit_valid), e_dv);
            chk("blank", int'(blank), e_blank);
            chk("pattern_err", int'(pattern_err), e_perr);
            chk("seq_err", int'(seq_err), e_serr);
            chk("locked", int'(locked), e_locked);
            chk("err_count", int'(err_count), e_err);
        end
    end

    int n_dv, n_pe, n_se, first_dv;

    task automatic hold(input logic [6:0] p, input int n);
        seg = p; n_dv = 0; n_pe = 0; n_se = 0; first_dv = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (digit_valid) begin
                if (first_dv < 0) first_dv = i;
                n_dv++;
            end
            n_pe += int'(pattern_err);
            n_se += int'(seq_err);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bcd"}, int'(bcd), 0);
        chk({tag, "_dv"}, int'(digit_valid), 0);
        chk({tag, "_blank"}, int'(blank), 0);
        chk({tag, "_perr"}, int'(pattern_err), 0);
        chk({tag, "_serr"}, int'(seq_err), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err_count), 0);
    endtask

    int tot_dv, tot_se, last_d, sel;
    logic [6:0] rp;

    initial begin
        #1 reset = 1'b1;
        seg = pat_tab[0];
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        reset = 1'b0;

        // first digit: exactly one pulse, S samples after the input register captures it
        hold(pat_tab[0], 6);
        chk("first_pulses", n_dv, 1);
        chk("first_latency", first_dv, S);
        chk("first_bcd", int'(bcd), 0);
        chk("first_locked", int'(locked), 1);
        tot_dv = n_dv; tot_se = n_se;

        for (int d = 1; d <= 10; d++) begin
            hold(pat_tab[d % 10], 6);
            tot_dv += n_dv; tot_se += n_se;
        end
        chk("count_pulses", tot_dv, 11);
        chk("count_seq_err", tot_se, 0);
        chk("count_bcd", int'(bcd), 0);
        chk("count_err", int'(err_count), 0);

        hold(pat_tab[1], 6);
        hold(pat_tab[2], 6);
        hold(pat_tab[3], 6);
        hold(pat_tab[8], 2);
        chk("glitch_pulses", n_dv + n_pe + n_se, 0);
        hold(pat_tab[3], 6);
        chk("return_pulses", n_dv + n_pe + n_se, 0);
        chk("glitch_bcd", int'(bcd), 3);

        hold(pat_tab[4], 6);
        chk("four_dv", n_dv, 1);
        hold(pat_tab[6], 6);
        chk("skip_seq_err", n_se, 1);
        chk("skip_err", int'(err_count), 1);
        hold(pat_tab[7], 6);
        chk("resync_dv", n_dv, 1);
        chk("resync_serr", n_se, 0);

        hold(7'b1010101, 6);
        chk("bad_perr", n_pe, 1);
        chk("bad_locked", int'(locked), 0);
        chk("bad_err", int'(err_count), 2);
        chk("bad_bcd", int'(bcd), 7);
        hold(7'h7F, 6);
        chk("blank_lvl", int'(blank), 1);
        chk("blank_pulses", n_dv + n_pe, 0);

        // reset while a pattern is two samples into its run
        seg = pat_tab[5];
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        #1 reset = 1'b0;
        hold(pat_tab[5], 8);
        chk("rearm_pulses", n_dv, 1);
        chk("rearm_latency", first_dv, S);

        for (int i = 0; i < 140; i++) begin
            hold(7'b1010101, 5);
            hold(7'b0101010, 5);
        end
        chk("sat_err", int'(err_count), SAT);
        chk("sat_model", e_err, SAT);

        last_d = 0;
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                last_d = (last_d + 1) % 10;
                rp = pat_tab[last_d];
            end else if (sel < 7) begin
                last_d = $urandom_range(0, 9);
                rp = pat_tab[last_d];
            end else if (sel == 7) begin
                rp = 7'h7F;
            end else begin
                rp = 7'($urandom);
            end
            hold(rp, $urandom_range(1, 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
